// File: rtl/riscv_if_id_ex.sv
// Three-stage RV32I front pipeline: PC generation, decode with register-file read, and ALU execute.
// ALU results write back into the local register file on the edge after they leave execute.
module riscv_if_id_ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [4:0]  rdi,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  funct3,
    output logic        exception,
    output logic [31:0] result,
    output logic [4:0]  rd,
    output logic        memfetch
);
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    logic [31:0] pc_q, pc_d;
    logic [4:0]  rdi_q, rdi_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        exc_q, exc_d;
    logic        invertb_q, invertb_d;
    logic        load_q, load_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q;
    logic        memfetch_q;
    logic [31:0] regs_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm_i;
    logic [4:0]  shamt;
    logic        wb_en;

    assign opcode  = instruction[6:0];
    assign rs1     = instruction[19:15];
    assign rs2     = instruction[24:20];
    assign f3      = instruction[14:12];
    assign imm_i   = {{20{instruction[31]}}, instruction[31:20]};
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    assign pc_d = bubble ? pc_q : pc_q + 32'd4;

    always_comb begin
        rdi_d     = 5'd0;
        a_d       = 32'd0;
        b_d       = 32'd0;
        funct3_d  = 3'b000;
        exc_d     = 1'b0;
        invertb_d = 1'b0;
        load_d    = 1'b0;
        if (!bubble) begin
            case (opcode)
                OPC_OPIMM: begin
                    rdi_d     = instruction[11:7];
                    a_d       = rs1_val;
                    b_d       = imm_i;
                    funct3_d  = f3;
                    invertb_d = (f3 == 3'b101) && instruction[30];
                end
                OPC_OP: begin
                    rdi_d     = instruction[11:7];
                    a_d       = rs1_val;
                    b_d       = rs2_val;
                    funct3_d  = f3;
                    invertb_d = ((f3 == 3'b000) || (f3 == 3'b101)) && instruction[30];
                end
                OPC_LOAD: begin
                    // Address generation reuses the adder, so funct3 is forced to ADD.
                    rdi_d  = instruction[11:7];
                    a_d    = rs1_val;
                    b_d    = imm_i;
                    load_d = 1'b1;
                end
                default: exc_d = 1'b1;
            endcase
        end
    end

    assign shamt = b_q[4:0];

    always_comb begin
        result_d = 32'd0;
        case (funct3_q)
            3'b000: result_d = invertb_q ? a_q - b_q : a_q + b_q;
            3'b001: result_d = a_q << shamt;
            3'b010: result_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            3'b011: result_d = (a_q < b_q) ? 32'd1 : 32'd0;
            3'b100: result_d = a_q ^ b_q;
            3'b101: result_d = invertb_q ? 32'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'b110: result_d = a_q | b_q;
            default: result_d = a_q & b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= 32'd0;
            rdi_q      <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            funct3_q   <= 3'b000;
            exc_q      <= 1'b0;
            invertb_q  <= 1'b0;
            load_q     <= 1'b0;
            result_q   <= 32'd0;
            rd_q       <= 5'd0;
            memfetch_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rdi_q      <= rdi_d;
            a_q        <= a_d;
            b_q        <= b_d;
            funct3_q   <= funct3_d;
            exc_q      <= exc_d;
            invertb_q  <= invertb_d;
            load_q     <= load_d;
            result_q   <= result_d;
            rd_q       <= rdi_q;
            memfetch_q <= load_q;
        end
    end

    // x0 is never selected because wb_en excludes rd_q == 0, so it stays at its reset value.
    assign wb_en = !memfetch_q && (rd_q != 5'd0);

    for (genvar gi = 0; gi < 32; gi++) begin : g_regs
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                regs_q[gi] <= 32'd0;
            else if (wb_en && (rd_q == 5'(gi)))
                regs_q[gi] <= result_q;
        end
    end

    assign pc        = pc_q;
    assign rdi       = rdi_q;
    assign a         = a_q;
    assign b         = b_q;
    assign funct3    = funct3_q;
    assign exception = exc_q;
    assign result    = result_q;
    assign rd        = rd_q;
    assign memfetch  = memfetch_q;
endmodule

// File: tb/tb_riscv_if_id_ex.sv
// Directed bench for riscv_if_id_ex: straight-line code, ALU ops, load, illegal opcode,
// asynchronous reset mid-stream and a single-cycle stall.
module tb_riscv_if_id_ex;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bubble = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc, a, b, result;
    logic [4:0]  rdi, rd;
    logic [2:0]  funct3;
    logic        exception, memfetch;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [32];
    logic [31:0] exp_res [32];
    logic [4:0]  exp_rd [32];
    logic        exp_mf [32];
    logic        exp_vld [32];

    localparam logic [31:0] NOP = 32'h0000_0013;

    riscv_if_id_ex dut (
        .clk(clk), .rst(rst), .bubble(bubble), .instruction(instruction),
        .pc(pc), .rdi(rdi), .a(a), .b(b), .funct3(funct3), .exception(exception),
        .result(result), .rd(rd), .memfetch(memfetch)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: the word for pc appears after the next edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) instruction <= NOP;
        else      instruction <= imem[pc[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rdx,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rdx, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rdx);
        return {f7, rs2, rs1, f3, rdx, 7'b0110011};
    endfunction

    task automatic prog(input int idx, input logic [31:0] w, input logic [4:0] erd,
                        input logic [31:0] eres, input logic emf);
        imem[idx]    = w;
        exp_rd[idx]  = erd;
        exp_res[idx] = eres;
        exp_mf[idx]  = emf;
        exp_vld[idx] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_rdi"}, 32'(rdi), 32'd0);
        check({tag, "_a"}, a, 32'd0);
        check({tag, "_b"}, b, 32'd0);
        check({tag, "_funct3"}, 32'(funct3), 32'd0);
        check({tag, "_exception"}, 32'(exception), 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_rd"}, 32'(rd), 32'd0);
        check({tag, "_memfetch"}, 32'(memfetch), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            imem[i] = NOP; exp_vld[i] = 1'b0; exp_rd[i] = 5'd0; exp_res[i] = 32'd0; exp_mf[i] = 1'b0;
        end
        prog(0,  enc_i(7'b0010011, 5, 3'b000, 0, 12'd42),  5,  32'd42,        1'b0);
        prog(1,  enc_i(7'b0010011, 6, 3'b000, 0, 12'd9),   6,  32'd9,         1'b0);
        prog(2,  enc_i(7'b0010011, 1, 3'b000, 0, 12'hFF8), 1,  32'hFFFF_FFF8, 1'b0);
        prog(5,  enc_r(7'b0100000, 6, 1, 3'b000, 2),       2,  32'hFFFF_FFEF, 1'b0);
        prog(6,  enc_i(7'b0010011, 3, 3'b101, 1, 12'h401), 3,  32'hFFFF_FFFC, 1'b0);
        prog(7,  enc_i(7'b0010011, 4, 3'b101, 1, 12'h001), 4,  32'h7FFF_FFFC, 1'b0);
        prog(8,  enc_r(7'b0000000, 0, 1, 3'b010, 8),       8,  32'd1,         1'b0);
        prog(9,  enc_r(7'b0000000, 0, 1, 3'b011, 9),       9,  32'd0,         1'b0);
        prog(10, enc_r(7'b0000000, 5, 1, 3'b100, 10),      10, 32'hFFFF_FFD2, 1'b0);
        prog(11, enc_r(7'b0000000, 6, 1, 3'b110, 11),      11, 32'hFFFF_FFF9, 1'b0);
        prog(12, enc_r(7'b0000000, 5, 1, 3'b111, 12),      12, 32'h0000_0028, 1'b0);
        prog(13, enc_i(7'b0010011, 13, 3'b001, 1, 12'h004), 13, 32'hFFFF_FF80, 1'b0);
        prog(14, enc_r(7'b0000000, 6, 5, 3'b000, 14),      14, 32'd51,        1'b0);
        prog(15, enc_i(7'b0000011, 7, 3'b010, 0, 12'd12),  7,  32'd12,        1'b1);
        prog(16, 32'h0000_007F,                            0,  32'd0,         1'b0);
        prog(18, enc_i(7'b0010011, 15, 3'b000, 7, 12'd0),  15, 32'd0,         1'b0);
        prog(19, enc_r(7'b0000000, 6, 1, 3'b101, 16),      16, 32'h007F_FFFF, 1'b0);
        prog(20, enc_r(7'b0100000, 6, 1, 3'b101, 17),      17, 32'hFFFF_FFFF, 1'b0);

        // Reset state, then straight-line run: word k reaches execute after tick k+3.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        check("pc_after_release", pc, 32'd0);
        for (int t = 1; t <= 23; t++) begin
            tick();
            check($sformatf("pc_t%0d", t), pc, 32'(4 * t));
            if (t == 3) begin
                check("dec_t3_a", a, 32'd0);
                check("dec_t3_b", b, 32'd9);
                check("dec_t3_funct3", 32'(funct3), 32'd0);
                check("dec_t3_exception", 32'(exception), 32'd0);
            end
            if (t == 7) begin
                check("dec_sub_a", a, 32'hFFFF_FFF8);
                check("dec_sub_b", b, 32'd9);
                check("dec_sub_rdi", 32'(rdi), 32'd2);
            end
            if (t == 17) begin
                check("dec_lw_funct3", 32'(funct3), 32'd0);
                check("dec_lw_b", b, 32'd12);
            end
            if (t == 18) begin
                check("dec_illegal_exception", 32'(exception), 32'd1);
                check("dec_illegal_rdi", 32'(rdi), 32'd0);
                check("dec_illegal_a", a, 32'd0);
            end
            if (t >= 3 && exp_vld[t - 3]) begin
                $display("tick %0d word %0d rd %0d result %h memfetch %0d", t, t - 3, rd, result, memfetch);
                check($sformatf("ex%0d_rd", t - 3), 32'(rd), 32'(exp_rd[t - 3]));
                check($sformatf("ex%0d_result", t - 3), result, exp_res[t - 3]);
                check($sformatf("ex%0d_memfetch", t - 3), 32'(memfetch), 32'(exp_mf[t - 3]));
            end
        end

        // Asynchronous reset between edges clears everything at once.
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        check("restart_pc0", pc, 32'd0);
        tick();
        check("restart_pc1", pc, 32'd4);
        tick();
        check("restart_pc2", pc, 32'd8);

        // One stalled edge: pc holds, decode latches a NOP that reaches execute one cycle later.
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        $display("stall tick pc %h rdi %0d a %h b %h", pc, rdi, a, b);
        check("stall_pc", pc, 32'd8);
        check("stall_rdi", 32'(rdi), 32'd0);
        check("stall_a", a, 32'd0);
        check("stall_b", b, 32'd0);
        check("stall_exception", 32'(exception), 32'd0);
        tick();
        $display("post-stall tick pc %h rd %0d result %h", pc, rd, result);
        check("poststall_pc", pc, 32'd12);
        check("poststall_rd", 32'(rd), 32'd0);
        check("poststall_result", result, 32'd0);
        check("poststall_rdi", 32'(rdi), 32'd1);
        check("poststall_b", b, 32'hFFFF_FFF8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/riscv_if_id_ex.md
# riscv_if_id_ex

Three-stage RV32I integer front pipeline: instruction fetch (PC generation), decode (register-file read and immediate extraction) and execute (ALU). It drives the fetch address to an external instruction memory and accepts the fetched word one cycle later. Execute results are written back into its own register file. It sits between the instruction memory and the memory/writeback stages of the core.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-low.
- bubble  in  1  stall: hold PC and insert a NOP into decode this cycle.
- instruction  in  32  word fetched from the address `pc` presented in the previous cycle.
- pc  out  32  fetch address.
- rdi  out  5  decode-stage destination register.
- a  out  32  decode-stage operand A (value of rs1).
- b  out  32  decode-stage operand B (immediate or rs2 value).
- funct3  out  3  decode-stage ALU function.
- exception  out  1  decode-stage illegal-instruction flag.
- result  out  32  execute-stage ALU result.
- rd  out  5  execute-stage destination register.
- memfetch  out  1  execute-stage flag: `result` is a load address.

## Operation
- **IF**
  - `pc` += 4 on every edge while `bubble` = 0.
  - `pc` holds while `bubble` = 1.
  - Wraps modulo 2^32.
- **ID** registers on each edge:
  - rs1 = instr[19:15], rs2 = instr[24:20], rdi = instr[11:7], funct3 = instr[14:12].
  - OP-IMM (0010011): a = x[rs1], b = sign-extended instr[31:20]. Internal invertb = instr[30] only when funct3 = 101.
  - OP (0110011): a = x[rs1], b = x[rs2]. invertb = instr[30] when funct3 is 000 or 101.
  - LOAD (0000011): a = x[rs1], b = sign-extended I-immediate. Forward funct3 = 000 to EX. Internal load flag = 1.
  - Any other opcode: exception = 1, rdi = 0, a = b = 0, funct3 = 000.
  - `bubble` = 1: latch a NOP instead of decoding (rdi = 0, a = b = 0, funct3 = 000, exception = 0, no load).
- **Register file**
  - 32×32; x0 always reads 0 and ignores writes.
  - Read combinationally during decode.
  - No forwarding: dependent instructions must be spaced by software.
- **EX** registers on each edge:
  - rd = rdi.
  - memfetch = load flag.
  - result is computed from a, b, funct3, invertb, with shamt = b[4:0]:
    - 000: a+b, or a−b when invertb.
    - 001: a << shamt.
    - 010: signed a<b ? 1 : 0.
    - 011: unsigned a<b ? 1 : 0.
    - 100: a^b.
    - 101: logical a >> shamt, or arithmetic when invertb.
    - 110: a|b.
    - 111: a&b.
- **Writeback**
  - On the edge after a result appears, x[rd] ← result when memfetch = 0 and rd ≠ 0.
  - Load data is out of scope.

## Timing
- **Reset** (rst = 0, asynchronous): pc, rdi, a, b, funct3, exception, result, rd and memfetch are all 0. Register file cleared to 0. Takes effect immediately, mid-operation included.
- **Latency**: word for address P arrives at `instruction` after edge E0 (pc becomes P+4).
  - Decode outputs are valid after E1.
  - Execute outputs are valid after E2.
  - Register-file write occurs at E3.
- **Throughput**: one instruction per cycle, with no internal stalls.
- **Simultaneous writeback and read of the same register**: decode sees the old value.
- **bubble**: affects only the edge where it is sampled high. Downstream stages keep advancing, so the NOP reaches EX one cycle later.

## Test plan
- **Straight-line OP-IMM**
  - Setup: mem[0] = addi x5,x0,42; mem[4] = addi x6,x0,9; bubble = 0.
  - After reset: pc = 0.
  - Tick 1: pc = 4.
  - Tick 2: pc = 8.
  - Tick 3: pc = 12, rd = 5, result = 42, exception = 0, funct3 = 000, a = 0, b = 9.
  - Tick 4: pc = 16, rd = 6, result = 9, exception = 0.
- **ALU coverage**
  - Sequence: addi x1,x0,−8; NOPs; then sub, srai, srli, slt, sltu, xor, or, and, slli against x1.
  - Required results:
    - srai x1,1 → 0xFFFFFFFC.
    - srli x1,1 → 0x7FFFFFFC.
    - slt x1,x0 → 1.
    - sltu x1,x0 → 0.
- **Stall**
  - Stimulus: bubble = 1 for one edge.
  - Required: pc holds. Next cycle rdi = 0, a = b = 0, exception = 0. One cycle later rd = 0, result = 0.
- **Illegal opcode**
  - Stimulus: 0x0000007F decoded.
  - Required: exception = 1, rdi = 0, and no register written.
- **Load**
  - Stimulus: lw x7,12(x0).
  - Required: memfetch = 1, result = 12, rd = 7, and x7 unchanged.
- **Reset mid-stream**
  - Stimulus: assert rst = 0 between clock edges.
  - Required: all outputs 0 immediately. After release, fetch restarts at pc = 0.
